dual_req_arbiter: RTL

DUAL_REQ_ARBITER -- requirements
Module: dual_req_arbiter

---
 rtl/arb_pkg.sv | 18 +
 rtl/arb_wait_cnt.sv | 46 ++++
 rtl/dual_req_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and defaults for the dual-requester arbiter
package arb_pkg;

    localparam int ARB_CNT_W_DEF    = 8;
    localparam int ARB_HOLD_MAX_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT2 = 2'd2
    } arb_state_e;

    typedef enum logic {
        LAST_1 = 1'b0,
        LAST_2 = 1'b1
    } arb_last_e;

endpackage

// File: rtl/arb_wait_cnt.sv
// rtl/arb_wait_cnt.sv - saturating per-requester wait counter with capture on grant entry
module arb_wait_cnt
    import arb_pkg::*;
#(
    parameter int CNT_W = ARB_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_i,
    input  logic             gnt_i,
    input  logic             load_i,
    output logic [CNT_W-1:0] wait_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             waiting;

    assign waiting = req_i && !gnt_i;

    // The entry cycle itself is a waiting cycle, so the captured value includes it.
    always_comb begin
        cnt_inc = cnt_q;
        if (waiting && (cnt_q != CNT_MAX)) begin
            cnt_inc = cnt_q + CNT_ONE;
        end
        wait_d = load_i ? cnt_inc : wait_q;
        cnt_d  = (load_i || !waiting) ? '0 : cnt_inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wait_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            wait_q <= wait_d;
        end
    end

    assign wait_o = wait_q;

endmodule

// File: rtl/dual_req_arbiter.sv
// rtl/dual_req_arbiter.sv - two-requester last-served arbiter with wait reporting
// Optional hold watchdog enabled by ARB_TIMEOUT_EN.
module dual_req_arbiter
    import arb_pkg::*;
#(
    parameter int CNT_W    = ARB_CNT_W_DEF,
    parameter int HOLD_MAX = ARB_HOLD_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req1,
    input  logic             req2,
    input  logic             done1,
    input  logic             done2,
    output logic             gnt1,
    output logic             gnt2,
    output logic             busy,
    output logic [CNT_W-1:0] wait1,
    output logic [CNT_W-1:0] wait2,
    output logic             timeout
);

    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("CNT_W must be at least 1");
    end
    if (HOLD_MAX < 1) begin : g_hold_chk
        $error("HOLD_MAX must be at least 1");
    end

    arb_state_e state_q, state_d;
    arb_last_e  last_q, last_d;
    logic       enter1, enter2;
    logic       expire;

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;

    assign expire = (hold_q == HOLD_W'(HOLD_MAX));
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= LAST_2;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Release on done, dropped request or watchdog; hand straight over if the other side waits.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req1 && (!req2 || (last_q == LAST_2))) begin
                    state_d = GNT1;
                end else if (req2) begin
                    state_d = GNT2;
                end
            end
            GNT1: begin
                if (done1 || !req1 || expire) begin
                    state_d = req2 ? GNT2 : IDLE;
                end
            end
            GNT2: begin
                if (done2 || !req2 || expire) begin
                    state_d = req1 ? GNT1 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        enter1 = (state_d == GNT1) && (state_q != GNT1);
        enter2 = (state_d == GNT2) && (state_q != GNT2);

        last_d = last_q;
        if (enter1) begin
            last_d = LAST_1;
        end else if (enter2) begin
            last_d = LAST_2;
        end

`ifdef ARB_TIMEOUT_EN
        // Only a release caused purely by the watchdog counts as a timeout.
        timeout_d = expire && (((state_q == GNT1) && req1 && !done1) ||
                               ((state_q == GNT2) && req2 && !done2));
        if (state_d == IDLE) begin
            hold_d = '0;
        end else if (state_d != state_q) begin
            hold_d = HOLD_W'(1);
        end else begin
            hold_d = hold_q + HOLD_W'(1);
        end
`endif
    end

    always_comb begin
        gnt1 = (state_q == GNT1);
        gnt2 = (state_q == GNT2);
        busy = gnt1 || gnt2;
`ifdef ARB_TIMEOUT_EN
        timeout = timeout_q;
`else
        timeout = 1'b0;
`endif
    end

    arb_wait_cnt #(.CNT_W(CNT_W)) u_wait1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  (req1),
        .gnt_i  (gnt1),
        .load_i (enter1),
        .wait_o (wait1)
    );

    arb_wait_cnt #(.CNT_W(CNT_W)) u_wait2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  (req2),
        .gnt_i  (gnt2),
        .load_i (enter2),
        .wait_o (wait2)
    );

endmodule
